// File: rtl/dbus_pkg.sv
// Shared constants for the data-bus router: region codes and pending-read ID encoding.
package dbus_pkg;

  localparam logic [3:0] MEM_BASE  = 4'h0;
  localparam logic [3:0] MMIO_BASE = 4'h8;

  localparam int unsigned MAX_SLV = 8;
  // One code past the largest slave index marks reads the router answers itself.
  localparam int unsigned ID_W    = $clog2(MAX_SLV + 1);

  typedef logic [ID_W-1:0] id_t;

  localparam id_t DECERR_ID = id_t'(MAX_SLV);

endpackage

// File: rtl/dbus_idfifo.sv
// Synchronous FIFO of pending read IDs; push is honoured when full if a pop happens alongside.
module dbus_idfifo
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_pop,
  input  id_t  i_id,
  output id_t  o_id,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  id_t           r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_id    = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_id;
        r_wptr        <= ptr_next(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_next(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbus_router.sv
// Data-bus router: address-decoded write/read fan-out with in-order read response steering.
// Optional DBUS_DECERR_EN: unmapped accesses are answered by the router and set decerr.
module dbus_router
  import dbus_pkg::*;
#(
  parameter int unsigned       NSLV     = 2,
  parameter logic [NSLV*4-1:0] SLV_BASE = {MMIO_BASE, MEM_BASE},
  parameter int unsigned       RD_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m_wready,
  input  logic [31:0]        m_waddr,
  input  logic [31:0]        m_wdata,
  input  logic [3:0]         m_wstrb,
  output logic               m_wvalid,
  input  logic               m_rready,
  input  logic [31:0]        m_raddr,
  output logic               m_rvalid,
  output logic               m_rresp,
  output logic [31:0]        m_rdata,
  output logic [NSLV-1:0]    s_wready,
  output logic [NSLV-1:0]    s_rready,
  output logic [31:0]        s_waddr,
  output logic [31:0]        s_wdata,
  output logic [3:0]         s_wstrb,
  output logic [31:0]        s_raddr,
  input  logic [NSLV-1:0]    s_wvalid,
  input  logic [NSLV-1:0]    s_rvalid,
  input  logic [NSLV-1:0]    s_rresp,
  input  logic [NSLV*32-1:0] s_rdata,
  output logic               decerr
);

  id_t  w_wdec, w_rdec, w_wid, w_rid, w_head;
  logic w_full, w_empty, w_push, w_pop, w_blocked;

  // Descending scan so the lowest matching index is the one left standing.
  function automatic id_t decode(input logic [3:0] code);
    id_t id;
    id = DECERR_ID;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if (SLV_BASE[4*i +: 4] == code) id = id_t'(i);
    end
    return id;
  endfunction

  assign w_wdec = decode(m_waddr[31:28]);
  assign w_rdec = decode(m_raddr[31:28]);

`ifdef DBUS_DECERR_EN
  assign w_wid = w_wdec;
  assign w_rid = w_rdec;
`else
  assign w_wid = (w_wdec == DECERR_ID) ? '0 : w_wdec;
  assign w_rid = (w_rdec == DECERR_ID) ? '0 : w_rdec;
`endif

  assign s_waddr = m_waddr;
  assign s_wdata = m_wdata;
  assign s_wstrb = m_wstrb;
  assign s_raddr = m_raddr;

  always_comb begin
    s_wready = '0;
    m_wvalid = 1'b0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (w_wid == id_t'(i)) begin
        s_wready[i] = m_wready;
        m_wvalid    = s_wvalid[i];
      end
    end
    if (w_wid == DECERR_ID) m_wvalid = m_wready;
  end

  // A response retiring this cycle frees the slot for a new request.
  assign w_blocked = w_full && !w_pop;

  always_comb begin
    s_rready = '0;
    m_rvalid = 1'b0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (w_rid == id_t'(i)) begin
        s_rready[i] = m_rready && !w_blocked;
        m_rvalid    = s_rvalid[i] && !w_blocked;
      end
    end
    if (w_rid == DECERR_ID) m_rvalid = m_rready && !w_blocked;
  end

  assign w_push = m_rready && m_rvalid;

  always_comb begin
    m_rresp = 1'b0;
    m_rdata = '0;
    if (!w_empty) begin
      for (int i = 0; i < int'(NSLV); i++) begin
        if (w_head == id_t'(i)) begin
          m_rresp = s_rresp[i];
          m_rdata = s_rdata[32*i +: 32];
        end
      end
      if (w_head == DECERR_ID) m_rresp = 1'b1;
    end
  end

  assign w_pop = m_rresp;

  dbus_idfifo #(
    .DEPTH (RD_DEPTH)
  ) u_idfifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_id    (w_rid),
    .o_id    (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef DBUS_DECERR_EN
  logic r_decerr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_decerr <= 1'b0;
    end else if ((m_wready && w_wid == DECERR_ID) || (w_push && w_rid == DECERR_ID)) begin
      r_decerr <= 1'b1;
    end
  end

  assign decerr = r_decerr;
`else
  assign decerr = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_router.sv
// Scoreboard bench for dbus_router: read expectations queued on accept, retired on m_rresp.
module tb_dbus_router;

  localparam int unsigned NSLV     = 2;
  localparam int unsigned RD_DEPTH = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               m_wready, m_wvalid, m_rready, m_rvalid, m_rresp, decerr;
  logic [31:0]        m_waddr, m_wdata, m_raddr, m_rdata;
  logic [3:0]         m_wstrb, s_wstrb;
  logic [31:0]        s_waddr, s_wdata, s_raddr;
  logic [NSLV-1:0]    s_wready, s_rready, s_wvalid, s_rvalid, s_rresp;
  logic [NSLV*32-1:0] s_rdata;

  dbus_router #(
    .NSLV     (NSLV),
    .SLV_BASE ({4'h8, 4'h0}),
    .RD_DEPTH (RD_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_wready (m_wready),
    .m_waddr  (m_waddr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_wvalid (m_wvalid),
    .m_rready (m_rready),
    .m_raddr  (m_raddr),
    .m_rvalid (m_rvalid),
    .m_rresp  (m_rresp),
    .m_rdata  (m_rdata),
    .s_wready (s_wready),
    .s_rready (s_rready),
    .s_waddr  (s_waddr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_raddr  (s_raddr),
    .s_wvalid (s_wvalid),
    .s_rvalid (s_rvalid),
    .s_rresp  (s_rresp),
    .s_rdata  (s_rdata),
    .decerr   (decerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned slv;
    logic [31:0] data;
    bit          err;
  } rd_t;

  rd_t         sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          pop_now;

`ifdef DBUS_DECERR_EN
  localparam bit DecErrEn = 1'b1;
`else
  localparam bit DecErrEn = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned model_sel(input logic [31:0] a);
    if (a[31:28] == 4'h0) return 0;
    if (a[31:28] == 4'h8) return 1;
    return DecErrEn ? NSLV : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_wready = 1'b0; m_waddr = '0; m_wdata = '0; m_wstrb = '0;
    m_rready = 1'b0; m_raddr = '0;
    s_wvalid = '0; s_rvalid = '0; s_rresp = '0; s_rdata = '0;
    pop_now  = 1'b0;
  endtask

  task automatic drive_rd(input logic [31:0] addr);
    m_rready = 1'b1;
    m_raddr  = addr;
    s_rvalid = '1;
  endtask

  // Model acceptance from queue occupancy; a pop in the same cycle frees a slot.
  task automatic check_rd(input string tag, input logic [31:0] addr, input logic [31:0] data);
    int unsigned     slv;
    bit              acc;
    logic [NSLV-1:0] exp_rr;
    rd_t             e;
    slv    = model_sel(addr);
    acc    = (sb_q.size() < RD_DEPTH) || pop_now;
    exp_rr = '0;
    if (acc && slv < NSLV) exp_rr = NSLV'(1) << slv;
    check({tag, ".s_rready"}, 32'(s_rready), 32'(exp_rr));
    check({tag, ".m_rvalid"}, 32'(m_rvalid), 32'(acc));
    if (acc) begin
      e.slv  = slv;
      e.err  = (slv >= NSLV);
      e.data = e.err ? 32'h0 : data;
      sb_q.push_back(e);
    end
  endtask

  task automatic drive_rsp();
    pop_now = 1'b0;
    if (sb_q.size() != 0) begin
      pop_now = 1'b1;
      if (!sb_q[0].err) begin
        s_rresp[sb_q[0].slv]          = 1'b1;
        s_rdata[32*sb_q[0].slv +: 32] = sb_q[0].data;
      end
    end
  endtask

  task automatic check_rsp(input string tag);
    rd_t e;
    check({tag, ".pending"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, ".m_rresp"}, 32'(m_rresp), 32'd1);
      check({tag, ".m_rdata"}, m_rdata, e.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #2;
    check("rst.m_rresp", 32'(m_rresp), 32'd0);
    check("rst.m_rdata", m_rdata, 32'h0);
    check("rst.decerr", 32'(decerr), 32'd0);
    step();

    // Write to MMIO slave, zero-latency handshake.
    idle();
    m_wready = 1'b1; m_waddr = 32'h8000_0004; m_wdata = 32'h1234; m_wstrb = 4'hF;
    s_wvalid = 2'b10;
    #2;
    check("wr1.s_wready", 32'(s_wready), 32'h2);
    check("wr1.m_wvalid", 32'(m_wvalid), 32'd1);
    check("wr1.s_waddr", s_waddr, 32'h8000_0004);
    check("wr1.s_wdata", s_wdata, 32'h1234);
    check("wr1.s_wstrb", 32'(s_wstrb), 32'hF);
    step();
    idle();
    m_wready = 1'b1; m_waddr = 32'h0000_0008; s_wvalid = 2'b10;
    #2;
    check("wr0.s_wready", 32'(s_wready), 32'h1);
    check("wr0.m_wvalid", 32'(m_wvalid), 32'd0);
    step();

    // Two reads back-to-back fill the FIFO, third stalls.
    idle(); drive_rd(32'h0000_0010); #2; check_rd("rd0", 32'h0000_0010, 32'hAAAA); step();
    idle(); drive_rd(32'h8000_0000); #2;
    check("rd1.s_raddr", s_raddr, 32'h8000_0000);
    check_rd("rd1", 32'h8000_0000, 32'hBBBB); step();
    for (int k = 0; k < 2; k++) begin
      idle(); drive_rd(32'h0000_0020); #2; check_rd("rd2_full", 32'h0000_0020, 32'hDEAD); step();
    end
    // Full FIFO: response and new request in the same cycle.
    idle(); drive_rd(32'h0000_0030); drive_rsp(); #2;
    check_rd("rd3_pushpop", 32'h0000_0030, 32'hCCCC);
    check_rsp("rsp0");
    step();
    idle(); drive_rd(32'h0000_0040); #2; check_rd("rd4_full", 32'h0000_0040, 32'hDEAD); step();
    // Non-head slave answering is ignored.
    idle(); s_rresp = 2'b01; s_rdata[31:0] = 32'hDEAD_BEEF; #2;
    check("nonhead.m_rresp", 32'(m_rresp), 32'd0);
    step();
    idle(); drive_rsp(); #2; check_rsp("rsp1"); step();
    idle(); drive_rsp(); #2; check_rsp("rsp2"); step();
    idle(); s_rresp = 2'b11; s_rdata = {32'h1111_1111, 32'h2222_2222}; #2;
    check("empty.m_rresp", 32'(m_rresp), 32'd0);
    check("empty.m_rdata", m_rdata, 32'h0);
    step();

    // Write and read accepted together to the same slave.
    idle();
    m_wready = 1'b1; m_waddr = 32'h8000_0100; s_wvalid = 2'b10;
    drive_rd(32'h8000_0200); #2;
    check("wrrd.s_wready", 32'(s_wready), 32'h2);
    check("wrrd.m_wvalid", 32'(m_wvalid), 32'd1);
    check_rd("wrrd", 32'h8000_0200, 32'h5A5A_0001);
    step();
    idle(); drive_rsp(); #2; check_rsp("wrrd_rsp"); step();

    // Unmapped region.
    idle();
    m_wready = 1'b1; m_waddr = 32'h4000_0000; s_wvalid = 2'b11;
    drive_rd(32'h4000_0000); #2;
    check("unm.s_wready", 32'(s_wready), DecErrEn ? 32'h0 : 32'h1);
    check("unm.m_wvalid", 32'(m_wvalid), 32'd1);
    check_rd("unm_rd", 32'h4000_0000, 32'h0BAD_0000);
    step();
    idle(); drive_rsp(); #2;
    check_rsp("unm_rsp");
    check("unm.decerr", 32'(decerr), 32'(DecErrEn));
    step();
    idle(); #2;
    check("unm.decerr_hold", 32'(decerr), 32'(DecErrEn));
    step();

    // Reset with two reads outstanding, then a stray response.
    idle(); drive_rd(32'h0000_0000); #2; check_rd("pre0", 32'h0000_0000, 32'h7777); step();
    idle(); drive_rd(32'h8000_0000); #2; check_rd("pre1", 32'h8000_0000, 32'h8888); step();
    idle(); reset = 1'b1; step(); reset = 1'b0;
    sb_q.delete();
    s_rresp = 2'b01; s_rdata[31:0] = 32'h5555_5555; #2;
    check("stray.m_rresp", 32'(m_rresp), 32'd0);
    check("stray.m_rdata", m_rdata, 32'h0);
    check("stray.decerr", 32'(decerr), 32'd0);
    step();
    idle(); drive_rd(32'h0000_0050); #2; check_rd("post_rst", 32'h0000_0050, 32'h9999); step();
    idle(); drive_rsp(); #2; check_rsp("post_rst_rsp"); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_router.md
DBUS_ROUTER -- requirements
Module: dbus_router

Interface
REQ-001 Parameter NSLV, default 2, number of slave channels (2..8).
REQ-002 Parameter SLV_BASE, default {4'h8,4'h0}, packed NSLV x 4-bit region codes matched against addr[31:28]; slave i uses bits [4i+3:4i].
REQ-003 Parameter RD_DEPTH, default 2, max outstanding reads (power of two, 1..8).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 m_wready/m_waddr/m_wdata/m_wstrb  input  1/32/32/4  master write request, address, data, byte strobe.
REQ-007 m_wvalid  output  1  write accepted this cycle.
REQ-008 m_rready/m_raddr  input  1/32  master read request, address.
REQ-009 m_rvalid  output  1  read request accepted this cycle.
REQ-010 m_rresp/m_rdata  output  1/32  read data valid, read data.
REQ-011 s_wready/s_rready  output  NSLV each  per-slave write/read request.
REQ-012 s_waddr/s_wdata/s_wstrb/s_raddr  output  32/32/4/32  broadcast to all slaves.
REQ-013 s_wvalid/s_rvalid/s_rresp  input  NSLV each  per-slave write accept, read accept, read data valid.
REQ-014 s_rdata  input  NSLV*32  per-slave read data, slave i at [32i+31:32i].
REQ-015 decerr  output  1  sticky decode-error flag.

Function
REQ-016 Decode: slave i selected when addr[31:28]==SLV_BASE[i]; lowest index wins on duplicate codes.
REQ-017 Write path combinational: s_wready[i]=m_wready&&sel_w[i]; m_wvalid=s_wvalid of selected slave; zero added latency.
REQ-018 Write handshake completes in the cycle m_wready&&m_wvalid; router holds no write state.
REQ-019 Read request combinational: s_rready[i]=m_rready&&sel_r[i]&&!full; m_rvalid=selected s_rvalid&&!full.
REQ-020 On read accept, router pushes selected slave index into pending-ID FIFO (depth RD_DEPTH).
REQ-021 Response: m_rresp=s_rresp[head], m_rdata=s_rdata[head] when FIFO non-empty; head popped when m_rresp=1; else m_rresp=0, m_rdata=0.
REQ-022 s_rresp from a non-head slave is ignored (slaves return in order; out-of-order is a slave protocol violation).
REQ-023 Full: no new read accepted while full, except push allowed in same cycle as pop.
REQ-024 Simultaneous push and pop: occupancy unchanged, order preserved; pointers wrap modulo RD_DEPTH.
REQ-025 Write and read may be accepted in the same cycle to different or same slave.

Reset
REQ-026 Reset clears FIFO pointers and count (empty), decerr=0; all combinational outputs then reflect empty state (m_rresp=0, m_rdata=0).
REQ-027 Reset mid-operation discards outstanding reads; subsequent stray s_rresp ignored.

Configuration
REQ-028 Macro DBUS_DECERR_EN: when defined, unmapped address is accepted by router itself (m_wvalid/m_rvalid=1, no slave request), write dropped, read enqueues internal ID returning m_rresp=1, m_rdata=32'h0 one cycle after accept when at head, and decerr set until reset.
REQ-029 Without DBUS_DECERR_EN: unmapped address routes to slave 0; decerr tied 0.

Structure
REQ-030 Package dbus_pkg holds region code constants (MEM_BASE=4'h0, MMIO_BASE=4'h8), DECERR_ID constant, and clog2-based ID width.
REQ-031 One sub-module dbus_idfifo: synchronous FIFO of slave IDs with push/pop/full/empty; all other logic inline.

Verification
REQ-032 NSLV=2: write 0x8000_0004 data 0x1234 with s_wvalid[1]=1 -> s_wready=2'b10, m_wvalid=1 same cycle.
REQ-033 Read 0x0000_0010 then 0x8000_0000 back-to-back, slaves answer 0xAAAA then 0xBBBB -> m_rdata 0xAAAA then 0xBBBB, in order.
REQ-034 RD_DEPTH=2, three reads with no s_rresp -> third m_rvalid=0, s_rready=0 until one response pops.
REQ-035 Full FIFO, response and new request same cycle -> request accepted, count stays 2.
REQ-036 DBUS_DECERR_EN, read 0x4000_0000 -> no s_rready, m_rresp=1 with 0x0 next cycle, decerr=1 until reset.
REQ-037 Reset with 2 reads pending, then s_rresp[0]=1 -> m_rresp stays 0.
